sram_rdata_encoder: RTL and testbench
=====================================

# sram_rdata_encoder

Parametrised read-path encoder for the SRAM memory controller. It sits between the N SRAM macros and the bus-side controller. It owns a small posted-write buffer and forwards pending write bytes into later reads, selecting per byte lane. It selects the addressed bank and replicates byte/half-word lanes to the ARM convention. All reads go through a two-stage pipeline that accepts one read per cycle.

## Interface
- N_SRAM, 4: number of SRAM banks (1..8).
- WB_DEPTH, 2: posted-write buffer entries (1..8).
- INVERT_CE_EN, 0: 1 = `sram_en` and `wr_byte_en` are active-low.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- rd_req  in  1  read issued to SRAM this cycle.
- rd_addr  in  32  read byte address.
- rd_size  in  2  0 = byte, 1 = half-word, 2 = word, 3 = illegal.
- sram_en  in  N_SRAM  bank enables, one-hot after polarity correction.
- ram_rData  in  N_SRAM x 32  bank read data, valid the cycle after `rd_req`.
- wr_push  in  1  enqueue a posted write.
- wr_addr  in  32  write address (word-aligned use of [31:2]).
- wr_data  in  32  write data.
- wr_byte_en  in  4  write byte enables (polarity per INVERT_CE_EN).
- wr_drain  in  1  controller has written the head entry to SRAM this cycle.
- drain_valid  out  1  buffer non-empty.
- drain_addr / drain_data / drain_be  out  32/32/4  head entry (drain_be active-high).
- wr_count  out  $clog2(WB_DEPTH+1)  occupied entries.
- wr_full  out  1  wr_count == WB_DEPTH.
- wr_overflow  out  1  sticky: push dropped while full.
- rvalid  out  1  one-cycle pulse, rData/rerr valid.
- rData  out  32  replicated read data.
- rerr  out  1  read error, qualifies rData = 32'hBAD1BAD1.

## Operation
- Stage 0 (cycle T, rd_req = 1) registers the following:
  - rd_addr, rd_size, and the polarity-corrected sram_en.
  - A forwarding snapshot: per byte lane, the data and a hit bit taken from the youngest buffer entry where addr[31:2] matches and the byte enable is set.
- The snapshot includes an entry pushed in cycle T (bypass). It also includes an entry drained in cycle T, because the SRAM does not yet hold that data at read time.
- Stage 1 (T+1):
  - Bank data is chosen by the one-hot `sram_en`.
  - Each lane takes the forwarded byte if its hit bit is set, else the bank byte.
  - Lane replication: byte gives {4{lane[addr[1:0]]}}; half-word gives {2{half[addr[1]]}}; word gives the data unchanged.
  - The result is registered into rData.
- rerr = 1 and rData = 32'hBAD1BAD1 if any of the following holds:
  - the bank enable is zero or has multiple bits set;
  - rd_size = 3;
  - a half-word has addr[0] = 1;
  - a word has addr[1:0] != 0.
- Write buffer is FIFO ordered.
  - A push while full is dropped and sets wr_overflow, unless wr_drain is asserted in the same cycle.
  - Push and drain in the same cycle: count is unchanged and the new entry goes to the tail.
  - Drain while empty is ignored.
  - wr_overflow clears only on reset.
- Reset (asynchronous) clears the buffer, rvalid, rerr, rData (0), wr_count, wr_full and wr_overflow. In-flight reads are discarded with no rvalid. The buffer resumes on the first edge after release.

## Timing
- Read latency: rd_req at T gives rvalid, rData and rerr at T+2. Throughput is one read per cycle; back-to-back reads never stall.
- rvalid pulses exactly once per rd_req.
- drain_* and wr_count/wr_full are registered and update on the edge after push/drain. drain_* are combinational from the head register.
- A push at T is forwardable to a read at T. A read at T-1 does not see a push at T.

## Structure
- Shared package `sram_ctrl_pkg` holds:
  - the size_t enum (SIZE_QUARTER_WORD = 0, SIZE_HALF_WORD = 1, SIZE_WORD = 2);
  - BAD_DATA = 32'hBAD1BAD1;
  - the wb_entry_t struct {addr[31:2], data, be}.
- Sub-module `sram_write_buffer`: circular FIFO plus per-byte youngest-match forwarding logic. The encoder instantiates it once.

## Test plan
- Word read, bank 2, ram_rData[2] = 32'h11223344, empty buffer → rData 32'h11223344 at T+2, rerr 0.
- Byte read at addr 0x...3, bank data 32'hAABBCCDD → rData 32'hAAAAAAAA. Half-word at addr 0x...2 → rData 32'hAABBAABB.
- Forwarding:
  - Push (0x100, 32'hDEADBEEF, be 4'b0011), then push (0x100, 32'h0000CAFE, be 4'b0001).
  - Word read of 0x100 in the same cycle as the second push, bank data 32'h12345678.
  - Expected rData = 32'h1234BEFE.
- Fill WB_DEPTH = 2:
  - A third push is dropped and wr_overflow = 1.
  - Push + drain when full gives count 2, the new head is the old second entry, and the overflow flag does not newly set.
- Errors: sram_en = 0, then sram_en with two bits set, then rd_size = 3, then a misaligned half-word → each gives rerr = 1 and rData 32'hBAD1BAD1.
- Reset during back-to-back reads: assert nRST low for 1 cycle mid-stream → no rvalid for the in-flight reads, all outputs 0, wr_count 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM controller read/write paths
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      SIZE_QUARTER_WORD = 2'd0,
      SIZE_HALF_WORD    = 2'd1,
      SIZE_WORD         = 2'd2
   } size_t;

   localparam logic [31:0] BAD_DATA = 32'hBAD1BAD1;

   typedef struct packed {
      logic [31:2] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wb_entry_t;

endpackage

// File: rtl/sram_write_buffer.sv
// rtl/sram_write_buffer.sv - posted-write circular FIFO with per-byte youngest-match forwarding
module sram_write_buffer
   import sram_ctrl_pkg::*;
#(
   parameter int WB_DEPTH = 2,
   localparam int CW = $clog2(WB_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  wb_entry_t     push_entry,
   input  logic          drain,
   input  logic [31:2]   lookup_addr,
   output logic [3:0]    fwd_hit,
   output logic [31:0]   fwd_data,
   output wb_entry_t     head_entry,
   output logic          head_valid,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          overflow
);

   localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

   wb_entry_t     mem [WB_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] walk;
   logic          do_push;
   logic          do_drain;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full       = (count == CW'(WB_DEPTH));
   assign head_valid = (count != '0);
   assign head_entry = mem[head];
   assign do_drain   = drain && head_valid;
   // A drain in the same cycle frees the slot the push needs.
   assign do_push    = push && (!full || do_drain);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < WB_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[tail] <= push_entry;
            tail      <= nxt(tail);
         end
         if (do_drain) head <= nxt(head);
         if (do_push && !do_drain)      count <= count + 1'b1;
         else if (do_drain && !do_push) count <= count - 1'b1;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   // Walk oldest to youngest so later matches win; the entry being pushed is youngest of all.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      walk     = head;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (CW'(i) < count && mem[walk].addr == lookup_addr) begin
            for (int b = 0; b < 4; b++) begin
               if (mem[walk].be[b]) begin
                  fwd_hit[b]        = 1'b1;
                  fwd_data[8*b +: 8] = mem[walk].data[8*b +: 8];
               end
            end
         end
         walk = nxt(walk);
      end
      if (do_push && push_entry.addr == lookup_addr) begin
         for (int b = 0; b < 4; b++) begin
            if (push_entry.be[b]) begin
               fwd_hit[b]         = 1'b1;
               fwd_data[8*b +: 8] = push_entry.data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/sram_rdata_encoder.sv
// rtl/sram_rdata_encoder.sv - two-stage SRAM read path with bank select, write forwarding and lane replication
module sram_rdata_encoder
   import sram_ctrl_pkg::*;
#(
   parameter int N_SRAM       = 4,
   parameter int WB_DEPTH     = 2,
   parameter int INVERT_CE_EN = 0,
   localparam int CW = $clog2(WB_DEPTH + 1)
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   rd_req,
   input  logic [31:0]            rd_addr,
   input  logic [1:0]             rd_size,
   input  logic [N_SRAM-1:0]      sram_en,
   input  logic [N_SRAM-1:0][31:0] ram_rData,
   input  logic                   wr_push,
   input  logic [31:0]            wr_addr,
   input  logic [31:0]            wr_data,
   input  logic [3:0]             wr_byte_en,
   input  logic                   wr_drain,
   output logic                   drain_valid,
   output logic [31:0]            drain_addr,
   output logic [31:0]            drain_data,
   output logic [3:0]             drain_be,
   output logic [CW-1:0]          wr_count,
   output logic                   wr_full,
   output logic                   wr_overflow,
   output logic                   rvalid,
   output logic [31:0]            rData,
   output logic                   rerr
);

   logic [N_SRAM-1:0] en_fix;
   logic [3:0]        be_fix;
   wb_entry_t         push_entry;
   wb_entry_t         head_entry;
   logic [3:0]        fwd_hit;
   logic [31:0]       fwd_data;
   logic              unused_addr_bits;

   logic              s1_valid;
   logic [1:0]        s1_lo;
   logic [1:0]        s1_size;
   logic [N_SRAM-1:0] s1_en;
   logic [3:0]        s1_hit;
   logic [31:0]       s1_fwd;

   logic [31:0]       bank_data;
   logic [31:0]       merged;
   logic [31:0]       result;
   logic              err;

   assign en_fix           = (INVERT_CE_EN != 0) ? ~sram_en : sram_en;
   assign be_fix           = (INVERT_CE_EN != 0) ? ~wr_byte_en : wr_byte_en;
   assign push_entry.addr  = wr_addr[31:2];
   assign push_entry.data  = wr_data;
   assign push_entry.be    = be_fix;
   assign unused_addr_bits = ^wr_addr[1:0];

   sram_write_buffer #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
      .clk         (CLK),
      .rst_n       (nRST),
      .push        (wr_push),
      .push_entry  (push_entry),
      .drain       (wr_drain),
      .lookup_addr (rd_addr[31:2]),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data),
      .head_entry  (head_entry),
      .head_valid  (drain_valid),
      .count       (wr_count),
      .full        (wr_full),
      .overflow    (wr_overflow)
   );

   assign drain_addr = {head_entry.addr, 2'b00};
   assign drain_data = head_entry.data;
   assign drain_be   = head_entry.be;

   always_comb begin
      bank_data = '0;
      merged    = '0;
      for (int b = 0; b < N_SRAM; b++) begin
         if (s1_en[b]) bank_data = bank_data | ram_rData[b];
      end
      for (int l = 0; l < 4; l++) begin
         merged[8*l +: 8] = s1_hit[l] ? s1_fwd[8*l +: 8] : bank_data[8*l +: 8];
      end
      err = !$onehot(s1_en) || (s1_size == 2'd3)
         || (s1_size == SIZE_HALF_WORD && s1_lo[0])
         || (s1_size == SIZE_WORD && s1_lo != 2'b00);
      if (s1_size == SIZE_QUARTER_WORD)   result = {4{merged[{s1_lo, 3'b000} +: 8]}};
      else if (s1_size == SIZE_HALF_WORD) result = {2{merged[{s1_lo[1], 4'b0000} +: 16]}};
      else                                result = merged;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_size  <= '0;
         s1_en    <= '0;
         s1_hit   <= '0;
         s1_fwd   <= '0;
         rvalid   <= 1'b0;
         rerr     <= 1'b0;
         rData    <= '0;
      end else begin
         s1_valid <= rd_req;
         if (rd_req) begin
            s1_lo   <= rd_addr[1:0];
            s1_size <= rd_size;
            s1_en   <= en_fix;
            s1_hit  <= fwd_hit;
            s1_fwd  <= fwd_data;
         end
         rvalid <= s1_valid;
         if (s1_valid) begin
            rerr  <= err;
            rData <= err ? BAD_DATA : result;
         end
      end
   end

endmodule

// File: tb/tb_sram_rdata_encoder.sv
// tb/tb_sram_rdata_encoder.sv - scoreboard bench for sram_rdata_encoder with directed vectors
module tb_sram_rdata_encoder;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             rd_req;
   logic [31:0]      rd_addr;
   logic [1:0]       rd_size;
   logic [3:0]       sram_en;
   logic [3:0][31:0] ram_rData;
   logic             wr_push;
   logic [31:0]      wr_addr;
   logic [31:0]      wr_data;
   logic [3:0]       wr_byte_en;
   logic             wr_drain;
   logic             drain_valid;
   logic [31:0]      drain_addr;
   logic [31:0]      drain_data;
   logic [3:0]       drain_be;
   logic [1:0]       wr_count;
   logic             wr_full;
   logic             wr_overflow;
   logic             rvalid;
   logic [31:0]      rData;
   logic             rerr;

   int               checks = 0;
   int               errors = 0;
   logic [32:0]      sb [$];
   logic [32:0]      mon_exp;
   logic [3:0][31:0] ram_next;

   always #5 CLK = ~CLK;

   sram_rdata_encoder #(.N_SRAM(4), .WB_DEPTH(2), .INVERT_CE_EN(0)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_size     (rd_size),
      .sram_en     (sram_en),
      .ram_rData   (ram_rData),
      .wr_push     (wr_push),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_byte_en  (wr_byte_en),
      .wr_drain    (wr_drain),
      .drain_valid (drain_valid),
      .drain_addr  (drain_addr),
      .drain_data  (drain_data),
      .drain_be    (drain_be),
      .wr_count    (wr_count),
      .wr_full     (wr_full),
      .wr_overflow (wr_overflow),
      .rvalid      (rvalid),
      .rData       (rData),
      .rerr        (rerr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Bank data for a read becomes visible the cycle after rd_req.
   task automatic tick();
      @(posedge CLK);
      #1;
      ram_rData = ram_next;
      rd_req    = 1'b0;
      wr_push   = 1'b0;
      wr_drain  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] en,
                     input logic [31:0] d, input logic want, input logic [31:0] exp_d,
                     input logic exp_e);
      rd_req  = 1'b1;
      rd_addr = a;
      rd_size = sz;
      sram_en = en;
      for (int b = 0; b < 4; b++) ram_next[b] = en[b] ? d : (32'h0F0F0000 | 32'(b));
      if (want) sb.push_back({exp_e, exp_d});
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_push    = 1'b1;
      wr_addr    = a;
      wr_data    = d;
      wr_byte_en = be;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
      chk({tag, "_rdata"}, rData, 32'd0);
      chk({tag, "_rerr"}, 32'(rerr), 32'd0);
      chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
      chk({tag, "_wr_full"}, 32'(wr_full), 32'd0);
      chk({tag, "_wr_overflow"}, 32'(wr_overflow), 32'd0);
      chk({tag, "_drain_valid"}, 32'(drain_valid), 32'd0);
      chk({tag, "_drain_addr"}, drain_addr, 32'd0);
   endtask

   always @(negedge CLK) begin
      if (nRST === 1'b1 && rvalid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rData %h rerr %b want no response", rData, rerr);
         end else begin
            mon_exp = sb.pop_front();
            chk("rdata", rData, mon_exp[31:0]);
            chk("rerr", 32'(rerr), 32'(mon_exp[32]));
         end
      end
   end

   initial begin
      nRST = 1'b0;
      rd_req = 1'b0; rd_addr = '0; rd_size = '0; sram_en = '0;
      wr_push = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0; wr_drain = 1'b0;
      ram_next = '0; ram_rData = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_state("reset");
      nRST = 1'b1;
      tick();

      // Bank select and lane replication, back-to-back
      rd(32'h1000, 2'd2, 4'b0100, 32'h11223344, 1, 32'h11223344, 0); tick();
      rd(32'h1003, 2'd0, 4'b0001, 32'hAABBCCDD, 1, 32'hAAAAAAAA, 0); tick();
      rd(32'h1002, 2'd1, 4'b1000, 32'hAABBCCDD, 1, 32'hAABBAABB, 0); tick();
      rd(32'h1000, 2'd0, 4'b0010, 32'hAABBCCDD, 1, 32'hDDDDDDDD, 0); tick();
      rd(32'h1000, 2'd1, 4'b0001, 32'hAABBCCDD, 1, 32'hCCDDCCDD, 0); tick();
      rd(32'h1001, 2'd0, 4'b0010, 32'hAABBCCDD, 1, 32'hCCCCCCCC, 0); tick();

      // Forwarding: earlier read misses, same-cycle push is bypassed, youngest byte wins
      rd(32'h100, 2'd2, 4'b0010, 32'h12345678, 1, 32'h12345678, 0); tick();
      push(32'h100, 32'hDEADBEEF, 4'b0011);
      rd(32'h100, 2'd2, 4'b0010, 32'h12345678, 1, 32'h1234BEEF, 0); tick();
      push(32'h100, 32'h0000CAFE, 4'b0001);
      rd(32'h100, 2'd2, 4'b0010, 32'h12345678, 1, 32'h1234BEFE, 0); tick();
      chk("fill_count", 32'(wr_count), 32'd2);
      chk("fill_full", 32'(wr_full), 32'd1);
      chk("fill_overflow", 32'(wr_overflow), 32'd0);
      chk("fill_head_addr", drain_addr, 32'h100);
      chk("fill_head_data", drain_data, 32'hDEADBEEF);
      chk("fill_head_be", 32'(drain_be), 32'h3);

      // Push + drain while full; the drained entry still forwards to the same-cycle read
      push(32'h300, 32'h33333333, 4'b1111);
      wr_drain = 1'b1;
      rd(32'h100, 2'd2, 4'b0001, 32'h12345678, 1, 32'h1234BEFE, 0); tick();
      chk("pd_count", 32'(wr_count), 32'd2);
      chk("pd_overflow", 32'(wr_overflow), 32'd0);
      chk("pd_head_data", drain_data, 32'h0000CAFE);
      chk("pd_head_be", 32'(drain_be), 32'h1);
      chk("pd_head_addr", drain_addr, 32'h100);

      // Push while full is dropped and never forwarded
      push(32'h200, 32'h11111111, 4'b1111);
      rd(32'h200, 2'd2, 4'b0100, 32'h55555555, 1, 32'h55555555, 0); tick();
      chk("ovf_flag", 32'(wr_overflow), 32'd1);
      chk("ovf_count", 32'(wr_count), 32'd2);
      chk("ovf_head_data", drain_data, 32'h0000CAFE);
      rd(32'h300, 2'd2, 4'b1000, 32'h00000000, 1, 32'h33333333, 0); tick();

      wr_drain = 1'b1; tick();
      chk("drain1_addr", drain_addr, 32'h300);
      chk("drain1_count", 32'(wr_count), 32'd1);
      wr_drain = 1'b1; tick();
      chk("drain2_count", 32'(wr_count), 32'd0);
      chk("drain2_valid", 32'(drain_valid), 32'd0);
      wr_drain = 1'b1; tick();
      chk("empty_drain_count", 32'(wr_count), 32'd0);
      chk("overflow_sticky", 32'(wr_overflow), 32'd1);

      // Error cases, back-to-back, then a clean read
      rd(32'h1000, 2'd2, 4'b0000, 32'h01020304, 1, 32'hBAD1BAD1, 1); tick();
      rd(32'h1000, 2'd2, 4'b0110, 32'h01020304, 1, 32'hBAD1BAD1, 1); tick();
      rd(32'h1000, 2'd3, 4'b0001, 32'h01020304, 1, 32'hBAD1BAD1, 1); tick();
      rd(32'h1001, 2'd1, 4'b0001, 32'h01020304, 1, 32'hBAD1BAD1, 1); tick();
      rd(32'h1002, 2'd2, 4'b0001, 32'h01020304, 1, 32'hBAD1BAD1, 1); tick();
      rd(32'h1004, 2'd2, 4'b0001, 32'h01020304, 1, 32'h01020304, 0); tick();
      repeat (3) tick();
      chk("sb_empty_mid", 32'(sb.size()), 32'd0);

      // Reset while reads are in flight: none of them may respond
      push(32'h400, 32'h44444444, 4'b1111);
      rd(32'h2000, 2'd2, 4'b0001, 32'h99999999, 0, 32'h0, 0); tick();
      rd(32'h2004, 2'd2, 4'b0001, 32'h88888888, 0, 32'h0, 0);
      #2;
      nRST = 1'b0;
      #1;
      chk_reset_state("async_rst");
      tick();
      nRST = 1'b1;
      repeat (4) tick();
      chk_reset_state("post_rst");

      rd(32'h3000, 2'd0, 4'b0001, 32'h000000A5, 1, 32'hA5A5A5A5, 0); tick();
      repeat (3) tick();
      chk("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
